lsu_rsp_collect: RTL

- Return path for LSU loads in the single-cycle RISC-V memory subsystem; the counterpart to the address-side region select.
- Accepts a load request, latches which region it targets (data memory 0x2000–0x3FFF, output buffer 0x7000–0x703F, else unmapped), and waits one cycle for the synchronous read data.
- Picks the correct source, then byte/half-aligns and sign/zero-extends the data.
- Presents the result on a valid/ready response port and holds it until it is accepted.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_rsp_collect_if.sv | 25 ++
 rtl/load_align.sv | 46 ++++
 rtl/lsu_rsp_collect.sv | 94 +++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU load-return path.
package lsu_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_DMEM, REG_OPBF} region_t;

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Region bounds: start inclusive, end exclusive.
  localparam logic [15:0] ADDR_DMEM_START = 16'h2000;
  localparam logic [15:0] ADDR_DMEM_END   = 16'h4000;
  localparam logic [15:0] ADDR_OPBF_START = 16'h7000;
  localparam logic [15:0] ADDR_OPBF_END   = 16'h7040;

endpackage

// File: rtl/lsu_rsp_collect_if.sv
// Request/response bundle between the LSU and the load-return collector.
interface lsu_rsp_collect_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_addr;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_datamem_rdata;
  logic [31:0] i_op_buf_rdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_funct3,
    input  i_datamem_rdata, i_op_buf_rdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_funct3,
    output i_datamem_rdata, i_op_buf_rdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension for RV32I loads.
// Optional LSU_MISALIGN_CHECK_EN flags misaligned halfword/word loads.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      F3_LW:   data = word;
      default: err  = 1'b1;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    if ((((funct3 == F3_LH) || (funct3 == F3_LHU)) && lane[0]) ||
        ((funct3 == F3_LW) && (lane != 2'd0))) begin
      data = '0;
      err  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/lsu_rsp_collect.sv
// Load return collector: latches region/lane/type, picks the read word a cycle
// later, aligns it and holds the result on a valid/ready port. See LSU_MISALIGN_CHECK_EN in load_align.
module lsu_rsp_collect
  import lsu_pkg::*;
#(
  parameter logic [15:0] START_DATAMEM = ADDR_DMEM_START,
  parameter logic [15:0] END_DATAMEM   = ADDR_DMEM_END,
  parameter logic [15:0] START_OP_BF   = ADDR_OPBF_START,
  parameter logic [15:0] END_OP_BF     = ADDR_OPBF_END
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lsu_rsp_collect_if.slave  bus
);

  state_t      state;
  region_t     region_q;
  region_t     region_d;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic [31:0] src_word;
  logic [31:0] aligned_data;
  logic        aligned_err;

  always_comb begin
    region_d = REG_NONE;
    if ((bus.i_req_addr >= START_DATAMEM) && (bus.i_req_addr < END_DATAMEM))
      region_d = REG_DMEM;
    else if ((bus.i_req_addr >= START_OP_BF) && (bus.i_req_addr < END_OP_BF))
      region_d = REG_OPBF;
  end

  always_comb begin
    case (region_q)
      REG_DMEM: src_word = bus.i_datamem_rdata;
      REG_OPBF: src_word = bus.i_op_buf_rdata;
      default:  src_word = '0;
    endcase
  end

  load_align u_align (
    .word   (src_word),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .data   (aligned_data),
    .err    (aligned_err)
  );

  // Unmapped loads still take the full WAIT cycle so latency never depends on the address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      region_q    <= REG_NONE;
      lane_q      <= 2'd0;
      funct3_q    <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            region_q <= region_d;
            lane_q   <= bus.i_req_addr[1:0];
            funct3_q <= bus.i_req_funct3;
            state    <= WAIT;
          end
        end
        WAIT: begin
          rsp_data_q  <= (region_q == REG_NONE) ? 32'h0 : aligned_data;
          rsp_err_q   <= (region_q == REG_NONE) | aligned_err;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = (state == IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;

endmodule
